// File: rtl/loopback_seq.sv
// loopback_seq: test sequencer for the prbs21 -> tx -> chan -> rx -> checker loopback path
// Resets the loopback checker, gates the PRBS source, waits for the checker to lock,
// then measures bit errors over N_BITS compared bits and reports a pass/fail verdict.
// Ports:
//   clk_i, rst_i (async, active-high)
//   start_i, abort_i              run control (abort has priority)
//   aligned_i, bit_valid_i, bit_err_i   checker status, synchronous to clk_i
//   prbs_en_o, lb_rst_o           PRBS source enable, checker reset
//   busy_o, done_o, pass_o, timeout_o, state_o   sequencer status
//   bit_cnt_o, err_cnt_o          compared bits / saturating error count
// Optional: define LB_SEQ_LOCK_LOSS_EN to fail the run if aligned_i drops in MEASURE.
module loopback_seq #(
  parameter int          RST_CYCLES    = 16,
  parameter int          ALIGN_TIMEOUT = 4096,
  parameter logic [63:0] N_BITS        = 64'd1000000,
  parameter int          ERR_W         = 32,
  parameter int          MAX_ERR       = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             aligned_i,
  input  logic             bit_valid_i,
  input  logic             bit_err_i,
  output logic             prbs_en_o,
  output logic             lb_rst_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             timeout_o,
  output logic [2:0]       state_o,
  output logic [63:0]      bit_cnt_o,
  output logic [ERR_W-1:0] err_cnt_o
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RESET   = 3'd1,
    ALIGN   = 3'd2,
    MEASURE = 3'd3,
    DONE    = 3'd4,
    FAIL    = 3'd5
  } state_t;
  localparam int T_MAX = (RST_CYCLES > ALIGN_TIMEOUT) ? RST_CYCLES : ALIGN_TIMEOUT;
  localparam int TW    = $clog2(T_MAX + 1);
  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [63:0]      bit_cnt_q, bit_cnt_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;
  logic             done_q, done_d;
  logic             prbs_en_q, prbs_en_d;
  logic             lb_rst_q, lb_rst_d;
  logic             busy;
  assign busy = state_q inside {RESET, ALIGN, MEASURE};
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    err_cnt_d = err_cnt_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    if (abort_i) begin
      state_d = IDLE;
    end else if (!busy && start_i) begin
      state_d   = RESET;
      timer_d   = '0;
      bit_cnt_d = '0;
      err_cnt_d = '0;
      pass_d    = 1'b0;
      timeout_d = 1'b0;
    end else if (state_q == RESET) begin
      timer_d = timer_q + 1'b1;
      if (timer_q == TW'(RST_CYCLES - 1)) begin
        state_d = ALIGN;
        timer_d = '0;
      end
    end else if (state_q == ALIGN) begin
      timer_d = timer_q + 1'b1;
      // lock on the last allowed cycle still counts as success
      if (aligned_i) begin
        state_d = MEASURE;
      end else if (timer_q == TW'(ALIGN_TIMEOUT - 1)) begin
        state_d   = FAIL;
        timeout_d = 1'b1;
      end
    end else if (state_q == MEASURE) begin
      if (bit_valid_i) begin
        bit_cnt_d = bit_cnt_q + 64'd1;
        err_cnt_d = (bit_err_i && !(&err_cnt_q)) ? err_cnt_q + 1'b1 : err_cnt_q;
      end
      // completing the measurement takes precedence over a simultaneous lock loss
      if (bit_cnt_d == N_BITS) begin
        state_d = DONE;
        pass_d  = 64'(err_cnt_d) <= 64'(MAX_ERR);
      end
`ifdef LB_SEQ_LOCK_LOSS_EN
      else if (!aligned_i) begin
        state_d = FAIL;
      end
`endif
    end
    // outputs are registered copies of what the next state implies
    prbs_en_d = state_d inside {RESET, ALIGN, MEASURE};
    lb_rst_d  = state_d == RESET;
    done_d    = (state_d == DONE || state_d == FAIL) && state_d != state_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      err_cnt_q <= '0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
      prbs_en_q <= 1'b0;
      lb_rst_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      err_cnt_q <= err_cnt_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
      prbs_en_q <= prbs_en_d;
      lb_rst_q  <= lb_rst_d;
    end
  end
  assign state_o   = state_q;
  assign prbs_en_o = prbs_en_q;
  assign busy_o    = prbs_en_q;
  assign lb_rst_o  = lb_rst_q;
  assign done_o    = done_q;
  assign pass_o    = pass_q;
  assign timeout_o = timeout_q;
  assign bit_cnt_o = bit_cnt_q;
  assign err_cnt_o = err_cnt_q;
endmodule

// File: tb/tb_loopback_seq.sv
// tb_loopback_seq: directed stimulus with a cycle-level reference model for loopback_seq
module tb_loopback_seq;
  localparam int     RST  = 4;
  localparam int     TO   = 20;
  localparam longint N    = 100;
  localparam int     EW   = 4;
  localparam int     MAXE = 2;
  localparam int     EMAX = (1 << EW) - 1;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, abort = 1'b0, aligned = 1'b0, valid = 1'b0, err = 1'b0;
  logic prbs_en_o, lb_rst_o, busy_o, done_o, pass_o, timeout_o;
  logic [2:0] state_o;
  logic [63:0] bit_cnt_o;
  logic [EW-1:0] err_cnt_o;
  int checks = 0, failures = 0;
  int lbc = 0, dc = 0, ac = 0;
  bit armed = 1'b0;
  int vmode = 0, amode = 0, err_n = 0, drop_at = 0, spam = 0;
  loopback_seq #(
    .RST_CYCLES(RST), .ALIGN_TIMEOUT(TO), .N_BITS(64'(N)), .ERR_W(EW), .MAX_ERR(MAXE)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .aligned_i(aligned),
    .bit_valid_i(valid), .bit_err_i(err), .prbs_en_o(prbs_en_o), .lb_rst_o(lb_rst_o),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
    .state_o(state_o), .bit_cnt_o(bit_cnt_o), .err_cnt_o(err_cnt_o)
  );
  always #5 clk = ~clk;
  typedef struct {
    int     st;
    int     t;
    longint bits;
    int     errs;
    bit     pass;
    bit     to;
    bit     done;
  } mdl_t;
  mdl_t m;
  function automatic mdl_t nxt(mdl_t c, bit s, bit a, bit al, bit v, bit e);
    mdl_t n = c;
    bit busy = c.st >= 1 && c.st <= 3;
    if (a) n.st = 0;
    else if (!busy && s) begin
      n.st = 1; n.t = 0; n.bits = 0; n.errs = 0; n.pass = 0; n.to = 0;
    end else if (c.st == 1) begin
      n.t = c.t + 1;
      if (n.t == RST) begin n.st = 2; n.t = 0; end
    end else if (c.st == 2) begin
      n.t = c.t + 1;
      if (al) n.st = 3;
      else if (n.t == TO) begin n.st = 5; n.to = 1; end
    end else if (c.st == 3) begin
      if (v) begin
        n.bits = c.bits + 1;
        if (e && c.errs < EMAX) n.errs = c.errs + 1;
      end
      if (n.bits == N) begin n.st = 4; n.pass = n.errs <= MAXE; end
`ifdef LB_SEQ_LOCK_LOSS_EN
      else if (!al) n.st = 5;
`endif
    end
    n.done = (n.st == 4 || n.st == 5) && n.st != c.st;
    return n;
  endfunction
  always @(posedge clk or posedge rst)
    if (rst) m <= '{default: 0};
    else m <= nxt(m, start, abort, aligned, valid, err);
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures < 40) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (!rst && armed) begin
      chk("state", 64'(state_o), 64'(m.st));
      chk("prbs_en", 64'(prbs_en_o), 64'(m.st >= 1 && m.st <= 3));
      chk("busy", 64'(busy_o), 64'(m.st >= 1 && m.st <= 3));
      chk("lb_rst", 64'(lb_rst_o), 64'(m.st == 1));
      chk("done", 64'(done_o), 64'(m.done));
      chk("bit_cnt", bit_cnt_o, 64'(m.bits));
      chk("err_cnt", 64'(err_cnt_o), 64'(m.errs));
      if (m.st >= 4) begin
        chk("pass", 64'(pass_o), 64'(m.pass));
        chk("timeout", 64'(timeout_o), 64'(m.to));
      end
      lbc += int'(lb_rst_o);
      dc  += int'(done_o);
      ac  += int'(state_o == 3'd2);
    end
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic run(input int stop_at, input int limit);
    int acnt = 0;
    bit hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      step();
      if (state_o == 3'd2) acnt++;
      if (done_o || (stop_at > 0 && state_o == 3'd3 && bit_cnt_o == 64'(stop_at))) begin
        hit = 1'b1;
        start = 1'b0;
      end else begin
        start = spam != 0;
        valid = vmode != 0 ? i[0] : 1'b1;
        err = bit_cnt_o < 64'(err_n);
        aligned = amode == 0 ? 1'b1 : amode == 1 ? 1'b0 : acnt >= 20;
        if (drop_at > 0 && state_o == 3'd3 && bit_cnt_o >= 64'(drop_at)) aligned = 1'b0;
      end
    end
    if (!hit) begin
      checks++;
      failures++;
      $display("FAIL run_bound: no completion within %0d cycles", limit);
    end
  endtask
  task automatic go(input int stop_at, input int limit);
    aligned = amode == 0;
    start = 1'b1;
    run(stop_at, limit);
  endtask
  int lb0, d0, a0;
  initial begin
    #3 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    armed = 1'b1;
    step();
    chk("rst_state", 64'(state_o), 0);
    chk("rst_bits", bit_cnt_o, 0);
    chk("rst_prbs", 64'(prbs_en_o), 0);
    chk("rst_done", 64'(done_o), 0);
    // 1: two errors, every cycle valid
    err_n = 2; lb0 = lbc; d0 = dc;
    go(0, 300);
    chk("s1_state", 64'(state_o), 4);
    chk("s1_bits", bit_cnt_o, 100);
    chk("s1_errs", 64'(err_cnt_o), 2);
    chk("s1_pass", 64'(pass_o), 1);
    chk("s1_model_bits", 64'(m.bits), 100);
    step();
    chk("s1_lbrst_cycles", 64'(lbc - lb0), 4);
    chk("s1_done_pulses", 64'(dc - d0), 1);
    // 2: three errors, 50% valid, start spammed while busy
    err_n = 3; vmode = 1; spam = 1;
    go(0, 500);
    chk("s2_state", 64'(state_o), 4);
    chk("s2_bits", bit_cnt_o, 100);
    chk("s2_errs", 64'(err_cnt_o), 3);
    chk("s2_pass", 64'(pass_o), 0);
    vmode = 0; spam = 0;
    // 3a: alignment never comes
    amode = 1; err_n = 0; a0 = ac; d0 = dc;
    go(0, 100);
    chk("s3_state", 64'(state_o), 5);
    chk("s3_timeout", 64'(timeout_o), 1);
    chk("s3_prbs", 64'(prbs_en_o), 0);
    step();
    chk("s3_align_cycles", 64'(ac - a0), 20);
    chk("s3_done_pulses", 64'(dc - d0), 1);
    // 3b: alignment on the final allowed cycle
    amode = 2; a0 = ac;
    go(0, 300);
    chk("s3b_state", 64'(state_o), 4);
    chk("s3b_timeout", 64'(timeout_o), 0);
    chk("s3b_align_cycles", 64'(ac - a0), 20);
    // 4: abort together with start at bit 50
    amode = 0; err_n = 5; d0 = dc;
    go(50, 200);
    abort = 1'b1; start = 1'b1;
    step();
    chk("s4_state", 64'(state_o), 0);
    chk("s4_bits", bit_cnt_o, 50);
    chk("s4_errs", 64'(err_cnt_o), 5);
    chk("s4_prbs", 64'(prbs_en_o), 0);
    chk("s4_lbrst", 64'(lb_rst_o), 0);
    start = 1'b0;
    step();
    abort = 1'b0;
    step();
    chk("s4_no_done", 64'(dc - d0), 0);
    chk("s4_idle_hold", bit_cnt_o, 50);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("s4_restart_state", 64'(state_o), 1);
    chk("s4_restart_bits", bit_cnt_o, 0);
    chk("s4_restart_errs", 64'(err_cnt_o), 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    // 5: error counter saturation
    err_n = 40;
    go(0, 300);
    chk("s5_errs", 64'(err_cnt_o), 15);
    chk("s5_bits", bit_cnt_o, 100);
    chk("s5_pass", 64'(pass_o), 0);
    // 6: lock drops at bit 30
    err_n = 0; drop_at = 30;
    go(0, 300);
`ifdef LB_SEQ_LOCK_LOSS_EN
    chk("s6_state", 64'(state_o), 5);
    chk("s6_bits", bit_cnt_o, 31);
    chk("s6_timeout", 64'(timeout_o), 0);
    chk("s6_pass", 64'(pass_o), 0);
`else
    chk("s6_state", 64'(state_o), 4);
    chk("s6_bits", bit_cnt_o, 100);
    chk("s6_pass", 64'(pass_o), 1);
`endif
    drop_at = 0;
    // asynchronous reset in the middle of a measurement
    go(20, 200);
    #2 rst = 1'b1;
    #1;
    chk("ar_state", 64'(state_o), 0);
    chk("ar_bits", bit_cnt_o, 0);
    chk("ar_prbs", 64'(prbs_en_o), 0);
    chk("ar_busy", 64'(busy_o), 0);
    step();
    rst = 1'b0;
    step();
    go(0, 300);
    chk("post_reset_bits", bit_cnt_o, 100);
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/loopback_seq.md
Name: loopback_seq

Overview:
Test sequencer for the serial loopback path: prbs21 source -> tx -> chan -> rx -> loopback checker.
- Resets the loopback checker and gates the PRBS source.
- Waits for the checker to align, then runs a bit-error-rate measurement over a fixed number of compared bits.
- Reports the bit count, the error count and a pass/fail verdict.
- Runs in the TX clock domain; bit_valid_i/bit_err_i/aligned_i are already synchronous to clk_i.

Parameters:
RST_CYCLES, 16, cycles lb_rst_o held high per run (>=1)
ALIGN_TIMEOUT, 4096, max cycles in ALIGN before failing (>=1)
N_BITS, 1000000, compared bits per measurement (>=1, < 2^64)
ERR_W, 32, error counter width
MAX_ERR, 0, pass if err_cnt_o <= MAX_ERR

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
start_i  in  1  start pulse; accepted only in IDLE, DONE or FAIL
abort_i  in  1  abort level/pulse; returns to IDLE
aligned_i  in  1  checker lock indication
bit_valid_i  in  1  one recovered bit compared this cycle
bit_err_i  in  1  compared bit mismatched; qualified by bit_valid_i
prbs_en_o  out  1  PRBS source enable
lb_rst_o  out  1  loopback checker reset
busy_o  out  1  state is RESET, ALIGN or MEASURE
done_o  out  1  1-cycle pulse on entry to DONE or FAIL
pass_o  out  1  verdict, valid while in DONE
timeout_o  out  1  alignment timed out, valid while in FAIL
state_o  out  3  IDLE=0 RESET=1 ALIGN=2 MEASURE=3 DONE=4 FAIL=5
bit_cnt_o  out  64  compared bits in current/last run
err_cnt_o  out  ERR_W  errors in current/last run, saturating

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; counters 0.
- All outputs are registered; state_o equals the current state register.
- IDLE/DONE/FAIL + start_i (abort_i low) -> RESET next cycle.
  - On that edge: bit_cnt_o, err_cnt_o, pass_o and timeout_o are cleared; the phase timer is loaded.
- RESET:
  - lb_rst_o=1 and prbs_en_o=1 for exactly RST_CYCLES cycles.
  - Then ALIGN; lb_rst_o is 0 from the first ALIGN cycle.
- ALIGN:
  - prbs_en_o=1; timer counts cycles spent in ALIGN.
  - aligned_i=1 -> MEASURE next cycle.
  - Otherwise, after ALIGN_TIMEOUT cycles in ALIGN -> FAIL with timeout_o=1.
  - If aligned_i rises on the final timeout cycle, aligned_i wins.
- MEASURE:
  - prbs_en_o=1.
  - Each cycle with bit_valid_i=1: bit_cnt_o+1; if bit_err_i=1 also err_cnt_o+1, holding at 2^ERR_W-1.
  - bit_err_i is ignored when bit_valid_i=0.
  - The cycle the count reaches N_BITS -> DONE next cycle; later bits are not counted.
- DONE:
  - prbs_en_o=0; pass_o=(err_cnt_o <= MAX_ERR), registered on entry.
  - Counters hold until the next start.
- FAIL: prbs_en_o=0; pass_o=0; counters hold.
- done_o: single-cycle pulse in the first cycle of DONE or FAIL.
- abort_i=1 in RESET/ALIGN/MEASURE -> IDLE next cycle.
  - prbs_en_o and lb_rst_o drop next cycle; no done_o pulse; counters hold their values.
- abort_i and start_i in the same cycle: abort wins, start is ignored.
- start_i during busy_o=1 is ignored.
- abort_i in IDLE/DONE/FAIL -> IDLE; counters hold.
- Async reset mid-run: immediate IDLE, all outputs 0.

Optional Feature:
- Macro: LB_SEQ_LOCK_LOSS_EN.
- Defined: in MEASURE, aligned_i=0 in any cycle -> FAIL next cycle; timeout_o stays 0; counters freeze at values including that cycle.
- Undefined: aligned_i is ignored outside ALIGN.

Test Plan:
1. Override RST_CYCLES=4, N_BITS=100, MAX_ERR=2. Start; aligned_i=1 from the first ALIGN cycle; bit_valid_i=1 every cycle; 2 error pulses -> lb_rst_o high exactly 4 cycles, bit_cnt_o=100, err_cnt_o=2, done_o one pulse, pass_o=1, state_o=4.
2. Same as scenario 1 with 3 errors, and bit_valid_i toggling 50% -> bit_cnt_o=100 after ~200 MEASURE cycles, err_cnt_o=3, pass_o=0.
3. ALIGN_TIMEOUT=20, aligned_i held 0 -> FAIL after 20 ALIGN cycles, timeout_o=1, prbs_en_o=0, done_o pulse. Repeat with aligned_i rising on cycle 20 -> MEASURE.
4. abort_i at bit 50 of MEASURE, asserted together with start_i -> IDLE next cycle, no done_o, bit_cnt_o=50. Then start -> counters cleared to 0 in RESET.
5. ERR_W=4, bit_err_i=1 on 40 valid bits -> err_cnt_o saturates at 15.
6. LB_SEQ_LOCK_LOSS_EN defined: aligned_i drops at bit 30 -> FAIL, timeout_o=0, pass_o=0. Macro undefined: same stimulus -> DONE at bit 100.
